// File: rtl/sram_arbiter_2port_if.sv
// sram_arbiter_2port_if: client-side bundle for the two-port SRAM arbiter.
// Port 0 and port 1 each carry a req/ack request channel (rnw, addr, wdata)
// and a read-return channel (rvalid, rdata). Masters drive requests; the
// arbiter (slave) returns acks and read data.
interface sram_arbiter_2port_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              rnw0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              rnw1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  modport master (
    output req0, rnw0, addr0, wdata0,
    output req1, rnw1, addr1, wdata1,
    input  ack0, rvalid0, rdata0,
    input  ack1, rvalid1, rdata1
  );

  modport slave (
    input  req0, rnw0, addr0, wdata0,
    input  req1, rnw1, addr1, wdata1,
    output ack0, rvalid0, rdata0,
    output ack1, rvalid1, rdata1
  );
endinterface

// File: rtl/sram_arbiter_2port.sv
// sram_arbiter_2port: two-requester arbiter/sequencer for a single-port
// synchronous SRAM with a 1-cycle registered read.
// Grant in cycle C (combinational ack), SRAM command registered in C+1,
// read data returned with a one-cycle rvalid pulse in C+2.
// Optional macro SRAM_ARBITER_ROUND_ROBIN_EN: round-robin on contention
// (last_grant register). Without it, port 0 has fixed priority.
module sram_arbiter_2port #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              sram_clock,
  input  logic              reset,
  input  logic              arb_enable,
  sram_arbiter_2port_if.slave bus,
  output logic              sram_select,
  output logic              sram_read_not_write,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_write_data,
  input  logic [DATA_W-1:0] sram_data_out
);

  logic              w_grant0;
  logic              w_grant1;
  logic              w_any_grant;
  logic              w_win_rnw;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_rvalid0;
  logic              w_rvalid1;

  logic              r_select;
  logic              r_rnw;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  // read tag pipeline: {valid, port} for the command in C+1 and C+2
  logic              r_tag1_v;
  logic              r_tag1_p;
  logic              r_tag2_v;
  logic              r_tag2_p;

  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
  // 1'b1 means port 1 was granted most recently
  logic              r_last_grant;
`endif

  // Grant decision and winner request mux; acks are gated by reset so they drop asynchronously.
  always_comb begin
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_win_rnw   = 1'b0;
    w_win_addr  = {ADDR_W{1'b0}};
    w_win_wdata = {DATA_W{1'b0}};
    if (arb_enable && !reset) begin
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
      w_grant0 = bus.req0 & (~bus.req1 | r_last_grant);
      w_grant1 = bus.req1 & (~bus.req0 | ~r_last_grant);
`else
      w_grant0 = bus.req0;
      w_grant1 = bus.req1 & ~bus.req0;
`endif
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
    if (w_grant1) begin
      w_win_rnw   = bus.rnw1;
      w_win_addr  = bus.addr1;
      w_win_wdata = bus.wdata1;
    end else begin
      w_win_rnw   = bus.rnw0;
      w_win_addr  = bus.addr0;
      w_win_wdata = bus.wdata0;
    end
  end

  assign w_any_grant = w_grant0 | w_grant1;
  assign bus.ack0    = w_grant0;
  assign bus.ack1    = w_grant1;

  // Register the winning request as the SRAM command; address/data hold when idle.
  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) begin
      r_select <= 1'b0;
      r_rnw    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= {ADDR_W{1'b0}};
      r_wdata  <= {DATA_W{1'b0}};
    end else if (w_any_grant) begin
      r_select <= 1'b1;
      r_rnw    <= w_win_rnw;
      r_we     <= ~w_win_rnw;
      r_addr   <= w_win_addr;
      r_wdata  <= w_win_wdata;
    end else begin
      r_select <= 1'b0;
      r_we     <= 1'b0;
    end
  end

  assign sram_select         = r_select;
  assign sram_read_not_write = r_rnw;
  assign sram_write_enable   = r_we;
  assign sram_address        = r_addr;
  assign sram_write_data     = r_wdata;

  // Shift read tags alongside the SRAM pipeline so the return reaches the right port.
  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) begin
      r_tag1_v <= 1'b0;
      r_tag1_p <= 1'b0;
      r_tag2_v <= 1'b0;
      r_tag2_p <= 1'b0;
    end else begin
      r_tag1_v <= w_any_grant & w_win_rnw;
      r_tag1_p <= w_grant1;
      r_tag2_v <= r_tag1_v;
      r_tag2_p <= r_tag1_p;
    end
  end

  assign w_rvalid0   = r_tag2_v & ~r_tag2_p;
  assign w_rvalid1   = r_tag2_v &  r_tag2_p;
  assign bus.rvalid0 = w_rvalid0;
  assign bus.rvalid1 = w_rvalid1;

  // Capture returned data on rvalid so rdata holds the last read between pulses.
  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) begin
      r_rdata0 <= {DATA_W{1'b0}};
      r_rdata1 <= {DATA_W{1'b0}};
    end else begin
      if (w_rvalid0) begin
        r_rdata0 <= sram_data_out;
      end else begin
        r_rdata0 <= r_rdata0;
      end
      if (w_rvalid1) begin
        r_rdata1 <= sram_data_out;
      end else begin
        r_rdata1 <= r_rdata1;
      end
    end
  end

  // The SRAM output register is only valid in C+2, so it is passed straight through during the pulse.
  assign bus.rdata0 = w_rvalid0 ? sram_data_out : r_rdata0;
  assign bus.rdata1 = w_rvalid1 ? sram_data_out : r_rdata1;

`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
  // Remember which port won last; reset favours port 0 on the first contention.
  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_grant0) begin
      r_last_grant <= 1'b0;
    end else if (w_grant1) begin
      r_last_grant <= 1'b1;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter_2port.sv
// tb_sram_arbiter_2port: directed bench with a behavioural SRAM and a read
// scoreboard. Expected read data comes from a reference memory updated on
// every acked write; each acked read is queued with its due cycle.
module tb_sram_arbiter_2port;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic              clk;
  logic              reset;
  logic              arb_en;
  logic              sram_select;
  logic              sram_rnw;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_dout;

  logic [DATA_W-1:0] sram_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem  [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;

  typedef struct {
    logic              port;
    logic [DATA_W-1:0] data;
    int                due;
  } sb_t;
  sb_t sb[$];

  sram_arbiter_2port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_arbiter_2port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .sram_clock          (clk),
    .reset               (reset),
    .arb_enable          (arb_en),
    .bus                 (bus),
    .sram_select         (sram_select),
    .sram_read_not_write (sram_rnw),
    .sram_write_enable   (sram_we),
    .sram_address        (sram_addr),
    .sram_write_data     (sram_wdata),
    .sram_data_out       (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // behavioural single-port SRAM, 1-cycle registered read
  always @(posedge clk) begin
    if (sram_select) begin
      if (!sram_rnw && sram_we) sram_mem[sram_addr] <= sram_wdata;
      else if (sram_rnw) sram_dout <= sram_mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: pop on rvalid, push on ack
  always @(negedge clk) begin
    sb_t e;
    chk("one_ack", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
    if (bus.rvalid0 || bus.rvalid1) begin
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rvalid_port", {30'd0, bus.rvalid1, bus.rvalid0}, e.port ? 32'd2 : 32'd1);
        chk("rvalid_cycle", cyc_cnt, e.due);
        chk("rdata", {24'd0, (bus.rvalid1 ? bus.rdata1 : bus.rdata0)}, {24'd0, e.data});
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc_cnt) begin
      chk("rvalid_missing", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    if (bus.ack0) begin
      if (bus.rnw0) sb.push_back('{1'b0, ref_mem[bus.addr0], cyc_cnt + 2});
      else ref_mem[bus.addr0] = bus.wdata0;
    end
    if (bus.ack1) begin
      if (bus.rnw1) sb.push_back('{1'b1, ref_mem[bus.addr1], cyc_cnt + 2});
      else ref_mem[bus.addr1] = bus.wdata1;
    end
  end

  initial begin
    for (int a = 0; a < (1<<ADDR_W); a++) begin
      sram_mem[a] = 8'h00;
      ref_mem[a]  = 8'h00;
    end
    sram_dout  = 8'h00;
    reset      = 1'b1;
    arb_en     = 1'b1;
    bus.req0   = 1'b0; bus.rnw0 = 1'b0; bus.addr0 = 16'h0000; bus.wdata0 = 8'h00;
    bus.req1   = 1'b0; bus.rnw1 = 1'b0; bus.addr1 = 16'h0000; bus.wdata1 = 8'h00;

    // reset state, ack suppressed during reset
    #2;
    bus.req0 = 1'b1;
    #1;
    chk("rst_ack0", {31'd0, bus.ack0}, 32'd0);
    chk("rst_select", {31'd0, sram_select}, 32'd0);
    chk("rst_we", {31'd0, sram_we}, 32'd0);
    chk("rst_rnw", {31'd0, sram_rnw}, 32'd0);
    chk("rst_addr", {16'd0, sram_addr}, 32'd0);
    chk("rst_wdata", {24'd0, sram_wdata}, 32'd0);
    chk("rst_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    chk("rst_rdata", {16'd0, bus.rdata1, bus.rdata0}, 32'd0);
    bus.req0 = 1'b0;
    cyc(); cyc();
    reset = 1'b0;

    // port 0 write 0x1234 <= 0xA5 then read it back
    cyc();
    bus.req0 = 1'b1; bus.rnw0 = 1'b0; bus.addr0 = 16'h1234; bus.wdata0 = 8'hA5;
    #2;
    chk("t1_wr_ack0", {31'd0, bus.ack0}, 32'd1);
    chk("t1_wr_ack1", {31'd0, bus.ack1}, 32'd0);
    cyc();
    chk("t1_select", {31'd0, sram_select}, 32'd1);
    chk("t1_we", {31'd0, sram_we}, 32'd1);
    chk("t1_rnw", {31'd0, sram_rnw}, 32'd0);
    chk("t1_addr", {16'd0, sram_addr}, 32'h1234);
    chk("t1_wdata", {24'd0, sram_wdata}, 32'hA5);
    bus.rnw0 = 1'b1;
    #2;
    chk("t1_rd_ack0", {31'd0, bus.ack0}, 32'd1);
    cyc();
    chk("t1_we_once", {31'd0, sram_we}, 32'd0);
    chk("t1_rd_select", {31'd0, sram_select}, 32'd1);
    chk("t1_rd_rnw", {31'd0, sram_rnw}, 32'd1);
    bus.req0 = 1'b0;
    #2;
    chk("t1_idle_ack0", {31'd0, bus.ack0}, 32'd0);
    cyc();
    chk("t1_rvalid0", {31'd0, bus.rvalid0}, 32'd1);
    chk("t1_rdata0", {24'd0, bus.rdata0}, 32'hA5);
    chk("t1_idle_select", {31'd0, sram_select}, 32'd0);
    cyc();
    chk("t1_rvalid0_pulse", {31'd0, bus.rvalid0}, 32'd0);
    chk("t1_rdata0_hold", {24'd0, bus.rdata0}, 32'hA5);

    // preload 0x0000 = 0x11, 0x0001 = 0x22, then both ports read continuously
    bus.req0 = 1'b1; bus.rnw0 = 1'b0; bus.addr0 = 16'h0000; bus.wdata0 = 8'h11;
    cyc();
    bus.addr0 = 16'h0001; bus.wdata0 = 8'h22;
    cyc();
    bus.rnw0 = 1'b1; bus.addr0 = 16'h0000;
    bus.req1 = 1'b1; bus.rnw1 = 1'b1; bus.addr1 = 16'h0001;
    for (int i = 0; i < 8; i++) begin
      #2;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
      chk("rr_ack0", {31'd0, bus.ack0}, {31'd0, i[0]});
      chk("rr_ack1", {31'd0, bus.ack1}, {31'd0, ~i[0]});
`else
      chk("fp_ack0", {31'd0, bus.ack0}, 32'd1);
      chk("fp_ack1_starved", {31'd0, bus.ack1}, 32'd0);
`endif
      cyc();
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    cyc(); cyc(); cyc();

    // port 1 write 0xFFFF <= 0x5A, port 0 reads it on the next grant
    bus.req1 = 1'b1; bus.rnw1 = 1'b0; bus.addr1 = 16'hFFFF; bus.wdata1 = 8'h5A;
    #2;
    chk("t3_ack1", {31'd0, bus.ack1}, 32'd1);
    cyc();
    chk("t3_addr_full", {16'd0, sram_addr}, 32'hFFFF);
    bus.req1 = 1'b0;
    bus.req0 = 1'b1; bus.rnw0 = 1'b1; bus.addr0 = 16'hFFFF;
    #2;
    chk("t3_ack0", {31'd0, bus.ack0}, 32'd1);
    cyc();
    bus.req0 = 1'b0;
    cyc();
    chk("t3_rvalid0", {31'd0, bus.rvalid0}, 32'd1);
    chk("t3_rdata0_raw", {24'd0, bus.rdata0}, 32'h5A);
    cyc();

    // arb_enable dropped the cycle after a read ack
    bus.req0 = 1'b1; bus.rnw0 = 1'b1; bus.addr0 = 16'h1234;
    #2;
    chk("t4_ack0", {31'd0, bus.ack0}, 32'd1);
    cyc();
    arb_en = 1'b0;
    bus.addr0 = 16'h0000;
    bus.req1 = 1'b1; bus.rnw1 = 1'b1; bus.addr1 = 16'h0001;
    #2;
    chk("t4_dis_ack0", {31'd0, bus.ack0}, 32'd0);
    chk("t4_dis_ack1", {31'd0, bus.ack1}, 32'd0);
    cyc();
    chk("t4_rvalid0", {31'd0, bus.rvalid0}, 32'd1);
    chk("t4_rdata0", {24'd0, bus.rdata0}, 32'hA5);
    chk("t4_no_issue", {31'd0, sram_select}, 32'd0);
    cyc();
    chk("t4_drained", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    bus.req0 = 1'b0; bus.req1 = 1'b0; arb_en = 1'b1;
    cyc();

    // reset in the cycle after a read ack aborts the read
    bus.req0 = 1'b1; bus.rnw0 = 1'b1; bus.addr0 = 16'h0001;
    #2;
    chk("t5_ack0", {31'd0, bus.ack0}, 32'd1);
    cyc();
    chk("t5_pre_select", {31'd0, sram_select}, 32'd1);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("t5_rst_ack0", {31'd0, bus.ack0}, 32'd0);
    chk("t5_rst_select", {31'd0, sram_select}, 32'd0);
    chk("t5_rst_rnw", {31'd0, sram_rnw}, 32'd0);
    chk("t5_rst_addr", {16'd0, sram_addr}, 32'd0);
    chk("t5_rst_rdata", {16'd0, bus.rdata1, bus.rdata0}, 32'd0);
    bus.req0 = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("t5_no_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    bus.req0 = 1'b1; bus.rnw0 = 1'b1; bus.addr0 = 16'h0000;
    bus.req1 = 1'b1; bus.rnw1 = 1'b1; bus.addr1 = 16'h0001;
    #2;
    chk("t5_first_ack0", {31'd0, bus.ack0}, 32'd1);
    chk("t5_first_ack1", {31'd0, bus.ack1}, 32'd0);
    cyc();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    cyc(); cyc(); cyc();
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter_2port.md
Name: sram_arbiter_2port

Overview:
- Two-requester arbiter and sequencer for the 65536x8 single-port synchronous SRAM (select / read_not_write / write_enable style interface, 1-cycle registered read).
- Accepts byte read/write requests from two masters with a req/ack handshake.
- Drives registered SRAM controls and returns read data with a per-port valid pulse.
- Sits between the SRAM instance and its clients, e.g. CPU (port 0) and display/DMA (port 1).

Parameters:
- ADDR_W, 16, address width; SRAM depth is 2^ADDR_W.
- DATA_W, 8, data width.

Ports:
- sram_clock  input  1  single clock for arbiter and SRAM.
- reset  input  1  asynchronous, active-high reset.
- arb_enable  input  1  when low, no new grants; in-flight reads still complete.
- req0 / req1  input  1  request from port n; held stable until acked.
- rnw0 / rnw1  input  1  1 = read, 0 = write.
- addr0 / addr1  input  ADDR_W  request address.
- wdata0 / wdata1  input  DATA_W  write data.
- ack0 / ack1  output  1  combinational; request accepted this cycle.
- rvalid0 / rvalid1  output  1  read data valid pulse.
- rdata0 / rdata1  output  DATA_W  read data, valid while rvalidn is high.
- sram_select  output  1  to SRAM select.
- sram_read_not_write  output  1  to SRAM read_not_write.
- sram_write_enable  output  1  to SRAM write_enable.
- sram_address  output  ADDR_W  to SRAM address.
- sram_write_data  output  DATA_W  to SRAM write_data.
- sram_data_out  input  DATA_W  from SRAM data_out.

Behaviour:
- Reset (async):
  - all sram_* outputs = 0; ack, rvalid = 0.
  - rdata0/1 = 0; last_grant = port 1, so port 0 wins first.
- Grant, cycle C:
  - only if arb_enable; ackn = 1 for at most one port; transfer occurs at the edge ending C.
  - one req: that port wins.
  - both req: winner chosen by arbitration policy (see Optional Feature).
- Issue, cycle C+1 (registered from winner):
  - sram_select = 1; sram_address, sram_read_not_write = rnw.
  - sram_write_enable = !rnw; sram_write_data = wdata.
- No grant in C: sram_select, sram_write_enable = 0 in C+1; address/data hold previous value.
- Read:
  - SRAM captures at end of C+1.
  - In C+2, rvalid of the granting port = 1 for exactly one cycle; its rdata = sram_data_out.
  - Read latency req-accept to rvalid = 2 cycles.
  - Tag pipeline: 2-stage shift of {valid, port} tracks outstanding reads.
- Write: no response beyond ack; write is in SRAM at end of C+1.
- Throughput: one access per cycle, back-to-back, any read/write mix.
- Read-after-write, same address, consecutive grants: read returns the new data (SRAM ordering guarantees it).
- rdata registered: updates only on rvalid; holds the last value otherwise.
- arb_enable low: acks forced 0; pending tag pipeline drains normally.
- Reset mid-read: tag pipeline cleared; no rvalid produced for the aborted read.
- Address wrap: none; full ADDR_W passed through unmodified.

Optional Feature:
- Macro SRAM_ARBITER_ROUND_ROBIN_EN.
- Defined, contention: grant goes to the port not granted most recently (last_grant register, updated on every grant).
- Defined, uncontended grants update last_grant too.
- Undefined: fixed priority, port 0 always wins contention; last_grant logic is absent.

Test Plan:
- Port 0 write 0x1234 <= 0xA5, then port 0 read 0x1234 -> ack0 each cycle requested; rvalid0 two cycles after the read ack; rdata0 = 0xA5; sram_write_enable high exactly one cycle.
- Both ports read continuously, addresses preloaded 0x0000 = 0x11, 0x0001 = 0x22, with SRAM_ARBITER_ROUND_ROBIN_EN -> acks alternate 0,1,0,1; rvalid0/rdata0 = 0x11 and rvalid1/rdata1 = 0x22 alternate.
- Same traffic without the macro -> ack1 never asserted while req0 held; port 1 starved.
- Port 1 write 0xFFFF <= 0x5A, immediately followed by port 0 read 0xFFFF -> rdata0 = 0x5A.
- arb_enable dropped the cycle after a read ack -> no further acks; rvalid for the in-flight read still appears.
- reset asserted in the cycle after a read ack -> no rvalid; all outputs 0 asynchronously; first grant after release goes to port 0.
